// File: rtl/pipe_pkg.sv
// Shared definitions for the D/E/M/W pipeline stage registers.
package pipe_pkg;

  localparam int          EXC_NONE   = 0;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          TNEW_W_DEF = 2;
  localparam int          EXC_W_DEF  = 6;

  // One-hot update mode, highest priority in the top bit.
  typedef enum logic [3:0] {
    MODE_LOAD   = 4'b0001,
    MODE_BUBBLE = 4'b0010,
    MODE_HOLD   = 4'b0100,
    MODE_FLUSH  = 4'b1000
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries one instruction and its decoded payload
// across a stage boundary with flush/hold/bubble/load update modes.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int NUM_OPS = 2,
  parameter int EXC_W   = EXC_W_DEF,
  parameter int TNEW_W  = TNEW_W_DEF,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       hold,
  input  logic                       bubble,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          pc8_i,
  input  logic [DATA_W-1:0]          instr_i,
  input  logic [DATA_W-1:0]          e32_i,
  input  logic [NUM_OPS*DATA_W-1:0]  v_i,
  input  logic [NUM_OPS*REG_W-1:0]   a_i,
  input  logic [REG_W-1:0]           a3_i,
  input  logic                       w_i,
  input  logic                       bd_i,
  input  logic [TNEW_W-1:0]          tnew_i,
  input  logic [EXC_W-1:0]           exccode_i,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          pc8_o,
  output logic [DATA_W-1:0]          instr_o,
  output logic [DATA_W-1:0]          e32_o,
  output logic [NUM_OPS*DATA_W-1:0]  v_o,
  output logic [NUM_OPS*REG_W-1:0]   a_o,
  output logic [REG_W-1:0]           a3_o,
  output logic                       w_o,
  output logic                       bd_o,
  output logic [TNEW_W-1:0]          tnew_o,
  output logic [EXC_W-1:0]           exccode_o,
  output logic                       exc_pending_o,
  output logic [CNT_W-1:0]           hold_cnt_o
);

  mode_e mode;

  logic                      valid_d,   valid_q;
  logic [DATA_W-1:0]         pc8_d,     pc8_q;
  logic [DATA_W-1:0]         instr_d,   instr_q;
  logic [DATA_W-1:0]         e32_d,     e32_q;
  logic [NUM_OPS-1:0][DATA_W-1:0] v_d, v_q;
  logic [NUM_OPS-1:0][REG_W-1:0]  a_d, a_q;
  logic [REG_W-1:0]          a3_d,      a3_q;
  logic                      w_d,       w_q;
  logic                      bd_d,      bd_q;
  logic [TNEW_W-1:0]         tnew_d,    tnew_q;
  logic [EXC_W-1:0]          exccode_d, exccode_q;

  // An empty incoming slot loads exactly like a bubble, so fold it in here.
  always_comb begin
    if (flush)                  mode = MODE_FLUSH;
    else if (hold)              mode = MODE_HOLD;
    else if (bubble || !valid_i) mode = MODE_BUBBLE;
    else                        mode = MODE_LOAD;
  end

  always_comb begin
    valid_d   = valid_q;
    pc8_d     = pc8_q;
    instr_d   = instr_q;
    e32_d     = e32_q;
    v_d       = v_q;
    a_d       = a_q;
    a3_d      = a3_q;
    w_d       = w_q;
    bd_d      = bd_q;
    tnew_d    = tnew_q;
    exccode_d = exccode_q;
    unique case (mode)
      MODE_FLUSH: begin
        valid_d   = 1'b0;
        pc8_d     = '0;
        instr_d   = DATA_W'(NOP_INSTR);
        e32_d     = '0;
        v_d       = '0;
        a_d       = '0;
        a3_d      = '0;
        w_d       = 1'b0;
        bd_d      = 1'b0;
        tnew_d    = '0;
        exccode_d = EXC_W'(EXC_NONE);
      end
      MODE_HOLD: begin
        tnew_d = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);
      end
      // pc8/bd survive so EPC and BD stay correct for a stalled slot.
      MODE_BUBBLE: begin
        valid_d   = 1'b0;
        pc8_d     = pc8_i;
        instr_d   = DATA_W'(NOP_INSTR);
        e32_d     = '0;
        v_d       = '0;
        a_d       = '0;
        a3_d      = '0;
        w_d       = 1'b0;
        bd_d      = bd_i;
        tnew_d    = '0;
        exccode_d = EXC_W'(EXC_NONE);
      end
      MODE_LOAD: begin
        valid_d   = valid_i;
        pc8_d     = pc8_i;
        instr_d   = instr_i;
        e32_d     = e32_i;
        v_d       = v_i;
        a_d       = a_i;
        a3_d      = a3_i;
        w_d       = w_i && valid_i && (exccode_i == EXC_W'(EXC_NONE));
        bd_d      = bd_i;
        tnew_d    = tnew_i;
        exccode_d = exccode_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc8_q     <= '0;
      instr_q   <= '0;
      e32_q     <= '0;
      v_q       <= '0;
      a_q       <= '0;
      a3_q      <= '0;
      w_q       <= 1'b0;
      bd_q      <= 1'b0;
      tnew_q    <= '0;
      exccode_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc8_q     <= pc8_d;
      instr_q   <= instr_d;
      e32_q     <= e32_d;
      v_q       <= v_d;
      a_q       <= a_d;
      a3_q      <= a3_d;
      w_q       <= w_d;
      bd_q      <= bd_d;
      tnew_q    <= tnew_d;
      exccode_q <= exccode_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (mode != MODE_HOLD),
    .inc   (mode == MODE_HOLD),
    .cnt_o (hold_cnt_o)
  );

  assign valid_o       = valid_q;
  assign pc8_o         = pc8_q;
  assign instr_o       = instr_q;
  assign e32_o         = e32_q;
  assign v_o           = v_q;
  assign a_o           = a_q;
  assign a3_o          = a3_q;
  assign w_o           = w_q;
  assign bd_o          = bd_q;
  assign tnew_o        = tnew_q;
  assign exccode_o     = exccode_q;
  assign exc_pending_o = valid_q && (exccode_q != EXC_W'(EXC_NONE));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed steps push expected state,
// a monitor compares after every rising edge.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, hold, bubble, valid_i, w_i, bd_i;
  logic [31:0] pc8_i, instr_i, e32_i;
  logic [63:0] v_i;
  logic [9:0]  a_i;
  logic [4:0]  a3_i;
  logic [1:0]  tnew_i;
  logic [5:0]  exccode_i;

  logic        valid_o, w_o, bd_o, exc_pending_o;
  logic [31:0] pc8_o, instr_o, e32_o;
  logic [63:0] v_o;
  logic [9:0]  a_o;
  logic [4:0]  a3_o;
  logic [1:0]  tnew_o;
  logic [5:0]  exccode_o;
  logic [3:0]  hold_cnt_o;

  // 3-channel, 16-bit instance sharing the control inputs.
  logic [15:0] p_pc8_i, p_instr_i, p_e32_i;
  logic [47:0] p_v_i;
  logic [14:0] p_a_i;
  logic        p_valid_o, p_w_o, p_bd_o, p_exc_pending_o;
  logic [15:0] p_pc8_o, p_instr_o, p_e32_o;
  logic [47:0] p_v_o;
  logic [14:0] p_a_o;
  logic [4:0]  p_a3_o;
  logic [1:0]  p_tnew_o;
  logic [5:0]  p_exccode_o;
  logic [3:0]  p_hold_cnt_o;

  assign p_pc8_i   = pc8_i[15:0];
  assign p_instr_i = instr_i[15:0];
  assign p_e32_i   = e32_i[15:0];
  assign p_a_i     = {a_i[4:0], a_i};

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .bubble(bubble),
    .valid_i(valid_i), .pc8_i(pc8_i), .instr_i(instr_i), .e32_i(e32_i),
    .v_i(v_i), .a_i(a_i), .a3_i(a3_i), .w_i(w_i), .bd_i(bd_i),
    .tnew_i(tnew_i), .exccode_i(exccode_i),
    .valid_o(valid_o), .pc8_o(pc8_o), .instr_o(instr_o), .e32_o(e32_o),
    .v_o(v_o), .a_o(a_o), .a3_o(a3_o), .w_o(w_o), .bd_o(bd_o),
    .tnew_o(tnew_o), .exccode_o(exccode_o), .exc_pending_o(exc_pending_o),
    .hold_cnt_o(hold_cnt_o)
  );

  pipe_stage_reg #(.DATA_W(16), .NUM_OPS(3)) dut_p (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .bubble(bubble),
    .valid_i(valid_i), .pc8_i(p_pc8_i), .instr_i(p_instr_i), .e32_i(p_e32_i),
    .v_i(p_v_i), .a_i(p_a_i), .a3_i(a3_i), .w_i(w_i), .bd_i(bd_i),
    .tnew_i(tnew_i), .exccode_i(exccode_i),
    .valid_o(p_valid_o), .pc8_o(p_pc8_o), .instr_o(p_instr_o), .e32_o(p_e32_o),
    .v_o(p_v_o), .a_o(p_a_o), .a3_o(p_a3_o), .w_o(p_w_o), .bd_o(p_bd_o),
    .tnew_o(p_tnew_o), .exccode_o(p_exccode_o), .exc_pending_o(p_exc_pending_o),
    .hold_cnt_o(p_hold_cnt_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic [31:0] e32;
    logic [63:0] v;
    logic [9:0]  a;
    logic [4:0]  a3;
    logic        w;
    logic        bd;
    logic [1:0]  tnew;
    logic [5:0]  exc;
    logic        pend;
    logic [3:0]  cnt;
    logic [47:0] pv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Monitor: every expectation applies to the edge after it was pushed.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("valid",    64'(valid_o),       64'(e.valid));
      chk("pc8",      64'(pc8_o),         64'(e.pc8));
      chk("instr",    64'(instr_o),       64'(e.instr));
      chk("e32",      64'(e32_o),         64'(e.e32));
      chk("v",        v_o,                e.v);
      chk("a",        64'(a_o),           64'(e.a));
      chk("a3",       64'(a3_o),          64'(e.a3));
      chk("w",        64'(w_o),           64'(e.w));
      chk("bd",       64'(bd_o),          64'(e.bd));
      chk("tnew",     64'(tnew_o),        64'(e.tnew));
      chk("exccode",  64'(exccode_o),     64'(e.exc));
      chk("pending",  64'(exc_pending_o), 64'(e.pend));
      chk("hold_cnt", 64'(hold_cnt_o),    64'(e.cnt));
      chk("p_v",      64'(p_v_o),         64'(e.pv));
      chk("p_valid",  64'(p_valid_o),     64'(e.valid));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e, ld, fl;
    reset = 1'b1; flush = 0; hold = 0; bubble = 0; valid_i = 0; w_i = 0; bd_i = 0;
    pc8_i = 0; instr_i = 0; e32_i = 0; v_i = 0; a_i = 0; a3_i = 0; tnew_i = 0;
    exccode_i = 0; p_v_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_pc8",   64'(pc8_o),   64'd0);
    chk("rst_cnt",   64'(hold_cnt_o), 64'd0);
    reset = 1'b0;

    // Plain load
    valid_i = 1; pc8_i = 32'h3008; instr_i = 32'h012A4020; e32_i = 32'h20;
    v_i = 64'hAAAA5555_11112222; a_i = {5'd9, 5'd10}; a3_i = 5'd8; w_i = 1;
    bd_i = 0; tnew_i = 2; exccode_i = 0; p_v_i = 48'hBEEF_1234_5678;
    ld = '0; ld.valid = 1; ld.pc8 = 32'h3008; ld.instr = 32'h012A4020; ld.e32 = 32'h20;
    ld.v = 64'hAAAA5555_11112222; ld.a = {5'd9, 5'd10}; ld.a3 = 5'd8; ld.w = 1;
    ld.tnew = 2; ld.pv = 48'hBEEF_1234_5678;
    exp_q.push_back(ld);
    @(negedge clk);

    // Hold 20 cycles with junk on the inputs
    hold = 1; pc8_i = 32'hDEAD; instr_i = '1; v_i = 0; p_v_i = 0; tnew_i = 3; exccode_i = 5;
    for (int i = 0; i < 20; i++) begin
      e = ld;
      e.tnew = (i == 0) ? 2'd1 : 2'd0;
      e.cnt  = (i < 15) ? 4'(i + 1) : 4'd15;
      exp_q.push_back(e);
      @(negedge clk);
    end

    // Next load clears the counter
    hold = 0; pc8_i = 32'h3010; instr_i = 32'h8C430004; e32_i = 32'h4;
    v_i = 64'h0000_0007_0000_0003; a_i = {5'd2, 5'd3}; a3_i = 5'd3; w_i = 1;
    tnew_i = 1; exccode_i = 0; p_v_i = 48'h0001_0002_0003;
    e = '0; e.valid = 1; e.pc8 = 32'h3010; e.instr = 32'h8C430004; e.e32 = 32'h4;
    e.v = 64'h0000_0007_0000_0003; e.a = {5'd2, 5'd3}; e.a3 = 5'd3; e.w = 1;
    e.tnew = 1; e.pv = 48'h0001_0002_0003;
    exp_q.push_back(e);
    @(negedge clk);

    // Bubble keeps pc8/bd only
    bubble = 1; pc8_i = 32'h300C; bd_i = 1;
    e = '0; e.pc8 = 32'h300C; e.bd = 1;
    exp_q.push_back(e);
    @(negedge clk);
    bubble = 0;

    // Load of an empty slot behaves as a bubble
    valid_i = 0; pc8_i = 32'h3014; bd_i = 1;
    e = '0; e.pc8 = 32'h3014; e.bd = 1;
    exp_q.push_back(e);
    @(negedge clk);

    // Faulting load: write-enable suppressed
    valid_i = 1; bd_i = 0; pc8_i = 32'h3018; instr_i = 32'h8C820001; e32_i = 32'h1;
    v_i = 64'h1234_5678_9ABC_DEF0; a_i = {5'd4, 5'd5}; a3_i = 5'd2; w_i = 1;
    tnew_i = 2; exccode_i = 6'd4; p_v_i = 48'hCAFE_0000_F00D;
    fl = '0; fl.valid = 1; fl.pc8 = 32'h3018; fl.instr = 32'h8C820001; fl.e32 = 32'h1;
    fl.v = 64'h1234_5678_9ABC_DEF0; fl.a = {5'd4, 5'd5}; fl.a3 = 5'd2; fl.w = 0;
    fl.tnew = 2; fl.exc = 6'd4; fl.pend = 1; fl.pv = 48'hCAFE_0000_F00D;
    exp_q.push_back(fl);
    @(negedge clk);

    // Hold beats bubble
    hold = 1; bubble = 1; pc8_i = 32'h5555;
    e = fl; e.tnew = 1; e.cnt = 1;
    exp_q.push_back(e);
    @(negedge clk);

    // Flush beats hold: everything cleared
    flush = 1; bubble = 0;
    e = '0;
    exp_q.push_back(e);
    @(negedge clk);
    flush = 0; hold = 0;

    // Load, hold 3 cycles, then async reset mid-hold
    pc8_i = 32'h3020; instr_i = 32'h00851020; e32_i = 0; v_i = 64'h5; a_i = {5'd5, 5'd4};
    a3_i = 5'd2; w_i = 1; tnew_i = 3; exccode_i = 0; p_v_i = 48'h7;
    e = '0; e.valid = 1; e.pc8 = 32'h3020; e.instr = 32'h00851020; e.v = 64'h5;
    e.a = {5'd5, 5'd4}; e.a3 = 5'd2; e.w = 1; e.tnew = 3; e.pv = 48'h7;
    exp_q.push_back(e);
    @(negedge clk);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      e.tnew = 2'(2 - i);
      e.cnt  = 4'(i + 1);
      exp_q.push_back(e);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("midrst_cnt",   64'(hold_cnt_o), 64'd0);
    chk("midrst_valid", 64'(valid_o),    64'd0);
    chk("midrst_pc8",   64'(pc8_o),      64'd0);
    chk("midrst_tnew",  64'(tnew_o),     64'd0);
    @(negedge clk);
    reset = 1'b0; hold = 0;

    // Final load: write enable low stays low, per-channel slices distinct
    pc8_i = 32'h301C; instr_i = 32'h03E00008; e32_i = 32'hFFFF_FFFC;
    v_i = 64'h0000_00FF_FF00_0000; a_i = {5'd31, 5'd1}; a3_i = 5'd0; w_i = 0;
    bd_i = 1; tnew_i = 3; exccode_i = 0; p_v_i = 48'h0000_BEEF_0000;
    e = '0; e.valid = 1; e.pc8 = 32'h301C; e.instr = 32'h03E00008; e.e32 = 32'hFFFF_FFFC;
    e.v = 64'h0000_00FF_FF00_0000; e.a = {5'd31, 5'd1}; e.bd = 1; e.tnew = 3;
    e.pv = 48'h0000_BEEF_0000;
    exp_q.push_back(e);
    @(negedge clk);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that succeeds the fixed-format decode/execute latch. It carries an instruction and its decoded payload across one stage boundary of the MIPS pipeline, with NUM_OPS operand channels of DATA_W bits. It supports four update modes with fixed priority: flush, hold, bubble and load. Beyond a plain latch it adds a valid bit, write-enable suppression for faulting instructions, saturating Tnew decrement while held, and a consecutive-hold counter for hazard and performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of pc8, instr, e32 and each operand value
- REG_W, 5, register-index width
- NUM_OPS, 2, number of source operand channels
- EXC_W, 6, exception-code width
- TNEW_W, 2, Tnew width
- CNT_W, 4, hold-counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  exception/eret kill; clears the stage, including pc8 and bd
- hold  in  1  downstream freeze; keep contents
- bubble  in  1  hazard stall; insert NOP, preserving pc8 and bd
- valid_i  in  1  incoming slot holds a real instruction
- pc8_i, instr_i, e32_i  in  DATA_W each  payload
- v_i  in  NUM_OPS*DATA_W  packed operand values, channel k at [k*DATA_W +: DATA_W]
- a_i  in  NUM_OPS*REG_W  packed source register indices
- a3_i  in  REG_W  destination register
- w_i  in  1  register write enable
- bd_i  in  1  branch-delay-slot flag
- tnew_i  in  TNEW_W  cycles until result is available
- exccode_i  in  EXC_W  0 means no exception
- All registered outputs, same widths: valid_o, pc8_o, instr_o, e32_o, v_o, a_o, a3_o, w_o, bd_o, tnew_o, exccode_o
- exc_pending_o  out  1  combinational: valid_o && exccode_o != 0
- hold_cnt_o  out  CNT_W  consecutive hold cycles, saturating

## Operation
Priority, evaluated per rising edge:
1. reset (async)
2. flush
3. hold
4. bubble
5. load

- **reset / flush:** every output goes to 0, including pc8_o, bd_o, tnew_o and hold_cnt_o.
- **hold:** all payload is kept. tnew_o becomes max(tnew_o-1, 0). hold_cnt_o increments, saturating at 2^CNT_W-1.
- **bubble:** valid_o, instr_o, v_o, a_o, a3_o, e32_o, w_o, tnew_o and exccode_o go to 0. pc8_o gets pc8_i and bd_o gets bd_i, so exception EPC/BD are still correct for a stalled slot. hold_cnt_o goes to 0.
- **load:**
  - All fields take their _i values.
  - w_o is w_i && valid_i && (exccode_i == 0): a faulting instruction never writes back.
  - If valid_i = 0, the stage loads as a bubble: pc8 and bd are kept from the inputs, everything else is 0.
  - hold_cnt_o goes to 0.
- Operand channels are independent, identical slices. NUM_OPS = 1 must work.

## Timing
- Latency: 1 cycle from _i to _o in load mode.
- No combinational path from any input to any registered output. exc_pending_o depends on registers only.
- Reset is asserted asynchronously and released synchronously by the surrounding reset logic. The block needs no internal synchronizer.
- Boundary cases:
  - **Reset mid-hold:** hold_cnt_o = 0 immediately.
  - **flush and hold together:** flush wins; the stage is cleared even though downstream is frozen.
  - **hold and bubble together:** hold wins and the bubble request is dropped. Upstream is responsible for also freezing.
  - **Counter saturation:** hold_cnt_o saturates at 15 (CNT_W = 4) and never wraps.
  - **Tnew:** tnew_o saturates at 0 under hold and never underflows.

## Structure
- Shared package pipe_pkg holds:
  - EXC_NONE = 0
  - the NOP instruction constant (0)
  - the TNEW_W and EXC_W defaults, for reuse by the D/E/M/W stage instances
- One sub-module, sat_counter (parametrised width, inc/clr, saturating), for hold_cnt_o. The Tnew decrement is inline.
- The mode select is a small priority decode into a one-hot {FLUSH, HOLD, BUBBLE, LOAD} used by all field registers.

## Test plan
- **Reset:** assert reset between edges with a loaded stage -> all outputs are 0 before the next clk edge.
- **Load:** valid_i = 1, pc8_i = 0x3008, instr_i = 0x012A4020, w_i = 1, tnew_i = 2 -> next cycle the outputs match, w_o = 1, exc_pending_o = 0.
- **Bubble:** bubble = 1 with pc8_i = 0x300C, bd_i = 1 -> instr_o = 0, w_o = 0, valid_o = 0, pc8_o = 0x300C, bd_o = 1.
- **Hold:** hold for 20 cycles with tnew_o = 2 -> tnew_o goes 1, 0, 0, …; payload unchanged; hold_cnt_o counts 1..15 then stays at 15; clears on the next load.
- **Fault:** load with exccode_i = 4 (AdEL), w_i = 1 -> w_o = 0, exccode_o = 4, exc_pending_o = 1. Then flush together with hold -> all outputs 0, including pc8_o.
- **Parameters:** NUM_OPS = 3, DATA_W = 16 -> each channel slice is passed independently; channel 2 value 0xBEEF appears only at v_o[47:32].
